// File: rtl/pinwheel_uart_pkg.sv
// Shared types and default timing constants for the two-requester UART transmit path.
package pinwheel_uart_pkg;

   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

   typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

   localparam int CLOCK_HZ               = 24_000_000;
   localparam int BAUD_RATE              = 1200;
   localparam int CLOCKS_PER_BIT_DEFAULT = CLOCK_HZ / BAUD_RATE;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: start bit, 8 data bits LSB first, stop bit, each CLOCKS_PER_BIT long.
module uart_tx_serializer
   import pinwheel_uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       start,
   output logic       ser_tx,
   output logic       busy,
   output logic       idle,
   output ser_state_t state
);

   localparam int TW = $clog2(CLOCKS_PER_BIT);
   localparam logic [TW-1:0] BIT_END = TW'(CLOCKS_PER_BIT - 1);

   ser_state_t     state_next;
   logic [TW-1:0]  timer;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           bit_done;
   logic           load;

   assign bit_done = (timer == BIT_END);

   // A new byte may be loaded in the final stop-bit cycle so consecutive frames abut.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         SER_IDLE: begin
            if (start) begin
               state_next = SER_START;
               load       = 1'b1;
            end
         end
         SER_START: if (bit_done) state_next = SER_DATA;
         SER_DATA:  if (bit_done && bit_idx == 3'd7) state_next = SER_STOP;
         SER_STOP: begin
            if (bit_done) begin
               if (start) begin
                  state_next = SER_START;
                  load       = 1'b1;
               end else begin
                  state_next = SER_IDLE;
               end
            end
         end
         default: state_next = SER_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= SER_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else if (load) begin
         shreg   <= data;
         timer   <= '0;
         bit_idx <= '0;
      end else if (state != SER_IDLE) begin
         if (bit_done) begin
            timer <= '0;
            if (state == SER_DATA) begin
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + 1'b1;
            end
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   always_comb begin
      ser_tx = 1'b1;
      case (state)
         SER_START: ser_tx = 1'b0;
         SER_DATA:  ser_tx = shreg[0];
         default:   ser_tx = 1'b1;
      endcase
   end

   assign busy = (state != SER_IDLE);
   assign idle = (state == SER_IDLE) || (state == SER_STOP && bit_done);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8N1 serial line between two byte requesters,
// gated by a synchronized host CTS and released on a mid-packet stall timeout.
module uart_tx_arbiter
   import pinwheel_uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       cts_n,
   output logic       ser_tx,
   output logic [1:0] grant,
   output logic       busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t    arb_state, arb_next;
   ser_state_t    ser_state;
   logic          owner, owner_next;
   logic          ptr, ptr_next;
   logic [CW-1:0] to_cnt;
   logic          cts_meta, cts_sync, cts_ok;
   logic          g_valid, g_last;
   logic [7:0]    g_data;
   logic          accept, to_en, ser_idle;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cts_meta <= 1'b1;
         cts_sync <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_sync <= cts_meta;
      end
   end

   assign cts_ok  = ~cts_sync;
   assign g_valid = owner ? req1_valid : req0_valid;
   assign g_last  = owner ? req1_last  : req0_last;
   assign g_data  = owner ? req1_data  : req0_data;

   // Handshake: a byte transfers in a cycle where the owner's valid and its ready are both 1;
   // ready depends on valid combinationally, and data/last are sampled only in that cycle.
   always_comb begin
      arb_next   = arb_state;
      owner_next = owner;
      ptr_next   = ptr;
      accept     = 1'b0;
      to_en      = 1'b0;
      case (arb_state)
         ARB_IDLE: begin
            if (req0_valid || req1_valid) begin
               arb_next = ARB_HOLD;
               if (ptr == 1'b0) owner_next = req0_valid ? 1'b0 : 1'b1;
               else             owner_next = req1_valid ? 1'b1 : 1'b0;
            end
         end
         ARB_HOLD: begin
            accept = g_valid && ser_idle && cts_ok;
            to_en  = !g_valid && (ser_state == SER_IDLE);
            if ((accept && g_last) || (to_en && to_cnt == TO_LAST)) begin
               arb_next = ARB_IDLE;
               ptr_next = ~owner;
            end
         end
         default: arb_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         arb_state <= ARB_IDLE;
         owner     <= 1'b0;
         ptr       <= 1'b0;
      end else begin
         arb_state <= arb_next;
         owner     <= owner_next;
         ptr       <= ptr_next;
      end
   end

   // Only a stall with the line quiet counts; a CTS hold keeps valid high and never releases.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                               to_cnt <= '0;
      else if (accept || arb_next != ARB_HOLD) to_cnt <= '0;
      else if (to_en)                          to_cnt <= to_cnt + 1'b1;
   end

   assign grant      = (arb_state == ARB_HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign req0_ready = accept && !owner;
   assign req1_ready = accept && owner;

   uart_tx_serializer #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_serializer (
      .clock (clock),
      .reset (reset),
      .data  (g_data),
      .start (accept),
      .ser_tx(ser_tx),
      .busy  (busy),
      .idle  (ser_idle),
      .state (ser_state)
   );

endmodule
